// File: rtl/pe_array_sequencer.sv
// Sequencer for the 3x3 FP32 convolution PE array: streams weights into the
// array, launches one image window at a time and serialises the kernel results.
module pe_array_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 9,
    parameter int NUM_KERNEL  = 64,
    parameter int PE_LATENCY  = 12,
    parameter int KW          = $clog2(NUM_KERNEL),
    parameter int TW          = $clog2(KERNEL_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_start,
    input  logic                             w_valid,
    input  logic [DATA_WIDTH-1:0]            w_data,
    output logic                             w_ready,
    output logic                             pe_w_we,
    output logic [KW-1:0]                    pe_w_kidx,
    output logic [TW-1:0]                    pe_w_tidx,
    output logic [DATA_WIDTH-1:0]            pe_w_data,
    input  logic                             img_valid,
    input  logic [DATA_WIDTH*KERNEL_SIZE-1:0] img_data,
    output logic                             img_ready,
    output logic [DATA_WIDTH*KERNEL_SIZE-1:0] pe_image,
    output logic                             pe_start,
    input  logic [DATA_WIDTH*NUM_KERNEL-1:0]  pe_result,
    output logic                             res_valid,
    output logic [DATA_WIDTH-1:0]            res_data,
    output logic [KW-1:0]                    res_kidx,
    output logic                             res_last,
    input  logic                             res_ready,
    output logic                             weights_loaded,
    output logic                             busy,
    output logic [15:0]                      win_count
);

    localparam int            LW     = $clog2(PE_LATENCY + 1);
    localparam logic [KW-1:0] LAST_K = KW'(NUM_KERNEL - 1);
    localparam logic [TW-1:0] LAST_T = TW'(KERNEL_SIZE - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, WAIT_IMG, RUN, DRAIN} state_t;

    state_t                            r_state;
    state_t                            w_nextState;
    logic [KW-1:0]                     r_wk;
    logic [TW-1:0]                     r_wt;
    logic                              r_weWe;
    logic [KW-1:0]                     r_weK;
    logic [TW-1:0]                     r_weT;
    logic [DATA_WIDTH-1:0]             r_weData;
    logic                              r_weightsLoaded;
    logic [DATA_WIDTH*KERNEL_SIZE-1:0] r_image;
    logic                              r_start;
    logic [LW-1:0]                     r_latCnt;
    logic [DATA_WIDTH*NUM_KERNEL-1:0]  r_snapshot;
    logic [KW-1:0]                     r_resKidx;
    logic [15:0]                       r_winCount;

    logic w_weightAccept;
    logic w_lastWeight;
    logic w_imgAccept;
    logic w_cfgGo;
    logic w_capture;
    logic w_resAccept;
    logic w_lastRes;
    logic [DATA_WIDTH-1:0] w_resWord;

    // An image handshake in WAIT_IMG takes priority over a simultaneous reload request.
    assign w_weightAccept = w_valid && (r_state == LOAD_W);
    assign w_lastWeight   = w_weightAccept && (r_wk == LAST_K) && (r_wt == LAST_T);
    assign w_imgAccept    = img_valid && (r_state == WAIT_IMG);
    assign w_cfgGo        = cfg_start && ((r_state == IDLE) || ((r_state == WAIT_IMG) && !img_valid));
    assign w_capture      = (r_state == RUN) && (r_latCnt == '0);
    assign w_resAccept    = res_ready && (r_state == DRAIN);
    assign w_lastRes      = w_resAccept && (r_resKidx == LAST_K);
    assign w_resWord      = r_snapshot[int'(r_resKidx) * DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:     if (w_cfgGo) w_nextState = LOAD_W;
                      else if (r_weightsLoaded) w_nextState = WAIT_IMG;
            LOAD_W:   if (w_lastWeight) w_nextState = WAIT_IMG;
            WAIT_IMG: if (w_imgAccept) w_nextState = RUN;
                      else if (w_cfgGo) w_nextState = LOAD_W;
            RUN:      if (w_capture) w_nextState = DRAIN;
            DRAIN:    if (w_lastRes) w_nextState = WAIT_IMG;
            default:  w_nextState = IDLE;
        endcase
    end

    // Weight streaming: kernel-major, tap-minor; the write strobe lags acceptance by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wk            <= '0;
            r_wt            <= '0;
            r_weWe          <= 1'b0;
            r_weK           <= '0;
            r_weT           <= '0;
            r_weData        <= '0;
            r_weightsLoaded <= 1'b0;
        end else begin
            r_weWe <= 1'b0;
            if (w_cfgGo) begin
                r_wk            <= '0;
                r_wt            <= '0;
                r_weightsLoaded <= 1'b0;
            end
            if (w_weightAccept) begin
                r_weWe   <= 1'b1;
                r_weK    <= r_wk;
                r_weT    <= r_wt;
                r_weData <= w_data;
                if (r_wt == LAST_T) begin
                    r_wt <= '0;
                    r_wk <= r_wk + KW'(1);
                end else begin
                    r_wt <= r_wt + TW'(1);
                end
                if (w_lastWeight) r_weightsLoaded <= 1'b1;
            end
        end
    end

    // The snapshot is taken on the cycle the latency counter sits at zero, i.e.
    // PE_LATENCY cycles after the pe_start cycle, when the array output is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_image    <= '0;
            r_start    <= 1'b0;
            r_latCnt   <= '0;
            r_snapshot <= '0;
            r_resKidx  <= '0;
            r_winCount <= '0;
        end else begin
            r_start <= 1'b0;
            if (w_imgAccept) begin
                r_image  <= img_data;
                r_start  <= 1'b1;
                r_latCnt <= LW'(PE_LATENCY);
            end
            if (r_state == RUN) begin
                if (w_capture) begin
                    r_snapshot <= pe_result;
                    r_resKidx  <= '0;
                end else begin
                    r_latCnt <= r_latCnt - LW'(1);
                end
            end
            if (w_resAccept) begin
                if (w_lastRes) begin
                    r_resKidx  <= '0;
                    r_winCount <= r_winCount + 16'd1;
                end else begin
                    r_resKidx <= r_resKidx + KW'(1);
                end
            end
        end
    end

    assign w_ready        = (r_state == LOAD_W);
    assign pe_w_we        = r_weWe;
    assign pe_w_kidx      = r_weK;
    assign pe_w_tidx      = r_weT;
    assign pe_w_data      = r_weData;
    assign img_ready      = (r_state == WAIT_IMG);
    assign pe_image       = r_image;
    assign pe_start       = r_start;
    assign res_valid      = (r_state == DRAIN);
    assign res_data       = (r_state == DRAIN) ? w_resWord : '0;
    assign res_kidx       = r_resKidx;
    assign res_last       = (r_state == DRAIN) && (r_resKidx == LAST_K);
    assign weights_loaded = r_weightsLoaded;
    assign busy           = (r_state != IDLE) && (r_state != WAIT_IMG);
    assign win_count      = r_winCount;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Scoreboard bench for pe_array_sequencer: random weight/window/backpressure
// stimulus against a behavioural PE-array and result-stream model.
module tb_pe_array_sequencer;

    localparam int DW  = 32;
    localparam int KS  = 9;
    localparam int NK  = 64;
    localparam int LAT = 12;
    localparam int KW  = 6;
    localparam int TW  = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_start;
    logic               w_valid;
    logic [DW-1:0]      w_data;
    logic               w_ready;
    logic               pe_w_we;
    logic [KW-1:0]      pe_w_kidx;
    logic [TW-1:0]      pe_w_tidx;
    logic [DW-1:0]      pe_w_data;
    logic               img_valid;
    logic [DW*KS-1:0]   img_data;
    logic               img_ready;
    logic [DW*KS-1:0]   pe_image;
    logic               pe_start;
    logic [DW*NK-1:0]   pe_result = '0;
    logic               res_valid;
    logic [DW-1:0]      res_data;
    logic [KW-1:0]      res_kidx;
    logic               res_last;
    logic               res_ready;
    logic               weights_loaded;
    logic               busy;
    logic [15:0]        win_count;

    pe_array_sequencer #(
        .DATA_WIDTH(DW), .KERNEL_SIZE(KS), .NUM_KERNEL(NK), .PE_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .pe_w_we(pe_w_we), .pe_w_kidx(pe_w_kidx), .pe_w_tidx(pe_w_tidx), .pe_w_data(pe_w_data),
        .img_valid(img_valid), .img_data(img_data), .img_ready(img_ready),
        .pe_image(pe_image), .pe_start(pe_start), .pe_result(pe_result),
        .res_valid(res_valid), .res_data(res_data), .res_kidx(res_kidx), .res_last(res_last),
        .res_ready(res_ready), .weights_loaded(weights_loaded), .busy(busy), .win_count(win_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [KW-1:0] k; logic [TW-1:0] t; logic [DW-1:0] d; } wexp_t;
    typedef struct { logic [DW-1:0] d; logic [KW-1:0] k; logic last; } rexp_t;

    wexp_t            wQ[$];
    rexp_t            rQ[$];
    logic [DW*KS-1:0] imgQ[$];
    logic [DW-1:0]    baseQ[$];
    longint           accQ[$];

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    longint      lastResCycle = -1;
    logic [15:0] winModel = '0;
    int          nStrobes = 0;
    int          rrMode = 0;
    int          cd = -1;
    logic [DW-1:0] curBase = '0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired", name);
    endtask

    function automatic logic [511:0] allOuts();
        return 512'({w_ready, pe_w_we, pe_w_kidx, pe_w_tidx, pe_w_data, img_ready, pe_image,
                     pe_start, res_valid, res_data, res_kidx, res_last, weights_loaded, busy, win_count});
    endfunction

    function automatic logic [DW*KS-1:0] randImg();
        logic [DW*KS-1:0] r;
        for (int k = 0; k < KS; k++) r[k*DW +: DW] = $urandom;
        return r;
    endfunction

    // Weight strobe monitor: each strobe must match the next accepted word.
    always @(negedge clk) begin
        wexp_t e;
        if (!rst && pe_w_we) begin
            nStrobes++;
            if (wQ.size() == 0) failNow("w_extra_strobe");
            else begin
                e = wQ.pop_front();
                checkOutput("w_strobe", 512'({pe_w_kidx, pe_w_tidx, pe_w_data}), 512'({e.k, e.t, e.d}));
            end
        end
    end

    // PE array model: result word k = base + k only during the cycle LAT after pe_start.
    always @(negedge clk) begin
        if (rst) cd = -1;
        else if (pe_start) begin
            if (imgQ.size() == 0) failNow("pe_start_unexpected");
            else begin
                checkOutput("pe_image", 512'(pe_image), 512'(imgQ.pop_front()));
                curBase = baseQ.pop_front();
                checkOutput("start_latency", 512'(cyc), 512'(accQ.pop_front() + 1));
            end
            cd = LAT;
        end else if (cd >= 0) cd--;
        for (int k = 0; k < NK; k++)
            pe_result[k*DW +: DW] = (cd == 0) ? curBase + DW'(k) : ~(curBase + DW'(k));
    end

    // Result monitor: compares the presented word every valid cycle, pops on handshake.
    always @(negedge clk) begin
        rexp_t r;
        if (!rst && res_valid) begin
            checkOutput("img_ready_in_drain", 512'(img_ready), 512'(0));
            if (rQ.size() == 0) failNow("res_extra_word");
            else begin
                r = rQ[0];
                checkOutput("res_word", 512'({res_data, res_kidx, res_last}), 512'({r.d, r.k, r.last}));
                if (res_ready) begin
                    void'(rQ.pop_front());
                    if (r.last) begin
                        winModel++;
                        lastResCycle = cyc;
                    end
                end
            end
        end
    end

    initial begin
        int ph = 0;
        res_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rrMode)
                1:       res_ready = (ph % 4 == 0) || (ph % 4 == 3);
                2:       res_ready = ($urandom_range(0, 1) == 1);
                default: res_ready = 1'b1;
            endcase
            ph++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulseCfg();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic loadWeights(input bit useIndex, output bit sawImgReady);
        int idx = 0;
        wexp_t e;
        sawImgReady = 0;
        for (int n = 0; n < 5000 && idx < NK*KS; n++) begin
            w_valid = ($urandom_range(0, 3) != 0);
            w_data  = useIndex ? DW'(idx) : DW'($urandom);
            @(negedge clk);
            if (img_ready) sawImgReady = 1;
            if (w_valid && w_ready) begin
                e.k = KW'(idx / KS);
                e.t = TW'(idx % KS);
                e.d = w_data;
                wQ.push_back(e);
                idx++;
            end
            tick();
        end
        w_valid = 1'b0;
        if (idx < NK*KS) failNow("weight_load_timeout");
    endtask

    task automatic checkLoadDone();
        checkOutput("weights_loaded_set", 512'(weights_loaded), 512'(1));
        checkOutput("w_ready_after_load", 512'(w_ready), 512'(0));
        checkOutput("img_ready_after_load", 512'(img_ready), 512'(1));
        tick();
        checkOutput("w_queue_drained", 512'(wQ.size()), 512'(0));
        checkOutput("strobe_count", 512'(nStrobes), 512'(NK*KS));
    endtask

    task automatic applyStimulus(input logic [DW*KS-1:0] img, input logic [DW-1:0] base);
        longint startCyc = cyc;
        bit     acc = 0;
        rexp_t  r;
        img_valid = 1'b1;
        img_data  = img;
        for (int n = 0; n < 2000 && !acc; n++) begin
            @(negedge clk);
            if (img_ready) begin
                acc = 1;
                checkOutput("acc_after_drain", 512'(rQ.size()), 512'(0));
                if (lastResCycle >= startCyc)
                    checkOutput("acc_b2b_timing", 512'(cyc), 512'(lastResCycle + 1));
                imgQ.push_back(img);
                baseQ.push_back(base);
                accQ.push_back(cyc);
                for (int k = 0; k < NK; k++) begin
                    r.d = base + DW'(k);
                    r.k = KW'(k);
                    r.last = (k == NK - 1);
                    rQ.push_back(r);
                end
            end
            tick();
        end
        img_valid = 1'b0;
        if (!acc) failNow("img_accept_timeout");
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((rQ.size() != 0 || imgQ.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) failNow("drain_timeout");
        tick();
    endtask

    initial begin
        bit saw;
        bit hit;
        rst = 1'b1; cfg_start = 1'b0; w_valid = 1'b0; w_data = '0;
        img_valid = 1'b0; img_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", allOuts(), 512'(0));
        rst = 1'b0;
        tick();
        checkOutput("idle_waits_for_cfg", 512'({busy, w_ready, img_ready}), 512'(0));

        $display("[TB] weight load with index data");
        nStrobes = 0;
        pulseCfg();
        checkOutput("load_entered", 512'({w_ready, busy, weights_loaded}), 512'(3'b110));
        loadWeights(1, saw);
        checkOutput("img_ready_low_in_load", 512'(saw), 512'(0));
        checkLoadDone();

        $display("[TB] single window");
        rrMode = 0;
        applyStimulus(288'hBDAC8916_BB9FA730_3DD99A1B_3E0D4FFB_3DFA1D08_3DB9172E_BB9FA730_BD8C0629_BDED8EF1,
                      32'h3F800000);
        waitDrain();
        checkOutput("win_count_single", 512'(win_count), 512'(1));

        $display("[TB] backpressure 1,0,0,1");
        rrMode = 1;
        applyStimulus(randImg(), $urandom);
        waitDrain();
        checkOutput("win_count_bp", 512'(win_count), 512'(winModel));

        $display("[TB] back-to-back windows");
        rrMode = 2;
        applyStimulus(randImg(), $urandom);
        applyStimulus(288'hBE78D32E_3E1A2B3C_BD4C5D6E_3F000000_BE800000_3DCCCCCD_BC23D70A_3E99999A_BF1FBD94,
                      $urandom);
        waitDrain();
        checkOutput("win_count_b2b", 512'(win_count), 512'(winModel));

        $display("[TB] cfg_start ignored in RUN and DRAIN");
        rrMode = 0;
        applyStimulus(randImg(), $urandom);
        repeat (3) tick();
        pulseCfg();
        checkOutput("cfg_in_run", 512'({weights_loaded, w_ready, busy}), 512'(3'b101));
        hit = 0;
        for (int n = 0; n < 100 && !hit; n++) begin
            @(negedge clk);
            if (res_valid) hit = 1;
        end
        if (!hit) failNow("drain_start_timeout");
        tick();
        pulseCfg();
        checkOutput("cfg_in_drain", 512'({weights_loaded, w_ready, busy}), 512'(3'b101));
        waitDrain();
        checkOutput("win_count_cfg_ignored", 512'(win_count), 512'(winModel));

        $display("[TB] reload from WAIT_IMG");
        nStrobes = 0;
        pulseCfg();
        checkOutput("reload_entered", 512'({weights_loaded, w_ready, img_ready}), 512'(3'b010));
        loadWeights(0, saw);
        checkOutput("img_ready_low_in_reload", 512'(saw), 512'(0));
        checkLoadDone();

        $display("[TB] random windows");
        for (int i = 0; i < 6; i++) begin
            rrMode = 2;
            applyStimulus(randImg(), $urandom);
            if ($urandom_range(0, 1) == 1) waitDrain();
        end
        waitDrain();
        checkOutput("win_count_random", 512'(win_count), 512'(winModel));

        $display("[TB] reset during drain");
        rrMode = 1;
        applyStimulus(randImg(), $urandom);
        hit = 0;
        for (int n = 0; n < 2000 && !hit; n++) begin
            @(negedge clk);
            if (res_valid && res_kidx == KW'(20)) hit = 1;
        end
        if (!hit) failNow("kidx20_timeout");
        rst = 1'b1;
        #1;
        checkOutput("async_reset_outputs", allOuts(), 512'(0));
        rQ.delete(); imgQ.delete(); baseQ.delete(); accQ.delete(); wQ.delete();
        winModel = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        checkOutput("post_reset_state", 512'({weights_loaded, busy, img_ready}), 512'(0));
        img_valid = 1'b1;
        img_data  = randImg();
        saw = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (img_ready) saw = 1;
            tick();
        end
        img_valid = 1'b0;
        checkOutput("no_img_ready_before_reload", 512'(saw), 512'(0));
        nStrobes = 0;
        pulseCfg();
        loadWeights(1, saw);
        checkLoadDone();
        rrMode = 2;
        applyStimulus(randImg(), $urandom);
        waitDrain();
        checkOutput("win_count_after_reset", 512'(win_count), 512'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
